// File: rtl/fm_modulate.sv
//----------------------------------------------------------------------------
// fm_modulate
//
// Baseband FM modulator. Pops one signed Q10 audio sample at a time from an
// input FIFO, scales it by DEV_GAIN and adds it to a wrapping 32-bit phase
// accumulator (2^32 = 2*pi). An iterative CORDIC rotator, running one step
// per cycle, turns the new phase into a Q10 I/Q pair. That pair is then
// pushed to the real/imag output FIFOs.
//
// Parameters:
//   ITER      CORDIC iterations (8..24)
//   DEV_GAIN  phase increment per audio LSB
//
// Ports:
//   clk               system clock, rising edge
//   reset             asynchronous, active-high reset
//   input_fifo_empty  audio FIFO empty flag
//   input_rd_en       audio FIFO pop (one cycle)
//   audio_in          signed Q10 audio sample at the FIFO head
//   out_fifos_full    OR of the real/imag output FIFO full flags
//   wr_en_out         one-cycle push to both output FIFOs
//   real_out          signed Q10 I sample (registered)
//   imag_out          signed Q10 Q sample (registered)
//
// Build option:
//   FM_MODULATE_LEADIN_EN  when defined, one priming sample (0x400, 0) is
//                          written after reset, before the first audio
//                          sample is read.
//----------------------------------------------------------------------------
module fm_modulate #(
    parameter int          ITER     = 16,
    parameter logic [31:0] DEV_GAIN = 32'h0012_C000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        input_fifo_empty,
    output logic        input_rd_en,
    input  logic [31:0] audio_in,
    input  logic        out_fifos_full,
    output logic        wr_en_out,
    output logic [31:0] real_out,
    output logic [31:0] imag_out
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ACCUM  = 3'd1;
    localparam logic [2:0] S_ROTATE = 3'd2;
    localparam logic [2:0] S_OUTPUT = 3'd3;
    localparam logic [2:0] S_LEADIN = 3'd4;

`ifdef FM_MODULATE_LEADIN_EN
    localparam logic [2:0] RESET_STATE = S_LEADIN;
`else
    localparam logic [2:0] RESET_STATE = S_IDLE;
`endif

    localparam logic [4:0]         LAST_ITER = 5'(ITER - 1);
    // CORDIC gain compensation K = 0.607253 in Q20.
    localparam logic signed [31:0] X_INIT    = 32'sd636751;

    // round(atan(2^-i) / (2*pi) * 2^32)
    function automatic logic signed [31:0] atan_tab(input logic [4:0] i);
        logic signed [31:0] a;
        case (i)
            5'd0:  a = 32'sd536870912;
            5'd1:  a = 32'sd316933406;
            5'd2:  a = 32'sd167458907;
            5'd3:  a = 32'sd85004756;
            5'd4:  a = 32'sd42667331;
            5'd5:  a = 32'sd21354465;
            5'd6:  a = 32'sd10679838;
            5'd7:  a = 32'sd5340245;
            5'd8:  a = 32'sd2670163;
            5'd9:  a = 32'sd1335087;
            5'd10: a = 32'sd667544;
            5'd11: a = 32'sd333772;
            5'd12: a = 32'sd166886;
            5'd13: a = 32'sd83443;
            5'd14: a = 32'sd41722;
            5'd15: a = 32'sd20861;
            5'd16: a = 32'sd10430;
            5'd17: a = 32'sd5215;
            5'd18: a = 32'sd2608;
            5'd19: a = 32'sd1304;
            5'd20: a = 32'sd652;
            5'd21: a = 32'sd326;
            5'd22: a = 32'sd163;
            5'd23: a = 32'sd81;
            default: a = 32'sd0;
        endcase
        return a;
    endfunction

    // Q20 -> Q10, rounding toward zero.
    function automatic logic signed [31:0] q20_to_q10(input logic signed [31:0] v);
        logic signed [31:0] b;
        b = v[31] ? v + 32'sd1023 : v;
        return b >>> 10;
    endfunction

    logic [2:0]         state;
    logic [31:0]        phase;
    logic [31:0]        audio_q;
    logic signed [31:0] x, y, z;
    logic               negate;
    logic [4:0]         iter_cnt;

    logic [31:0]        phase_inc;
    logic [31:0]        phase_next;
    logic               fold;
    logic signed [31:0] z_init;
    logic signed [31:0] x_n, y_n, z_n;
    logic signed [31:0] real_n, imag_n;

    assign input_rd_en = (state == S_IDLE) && !input_fifo_empty && !reset;
    assign wr_en_out   = (state == S_OUTPUT) && !out_fifos_full;

    // The low 32 bits of a product do not depend on signedness, so a plain
    // 32x32 multiply truncated to 32 bits is the signed product mod 2^32.
    assign phase_inc  = audio_q * DEV_GAIN;
    assign phase_next = phase + phase_inc;

    // Phases in quadrants 2 and 3 are rotated by pi, so the CORDIC only
    // sees angles in [-pi/2, pi/2). The result is negated back at the end.
    assign fold   = phase_next[31] ^ phase_next[30];
    assign z_init = fold ? $signed(phase_next - 32'h8000_0000) : $signed(phase_next);

    // NOTE: always_comb gives every target a value on every path; a missing
    // default here would infer a latch.
    always_comb begin
        x_n    = x;
        y_n    = y;
        z_n    = z;
        real_n = '0;
        imag_n = '0;
        if (z[31]) begin
            x_n = x + (y >>> iter_cnt);
            y_n = y - (x >>> iter_cnt);
            z_n = z + atan_tab(iter_cnt);
        end else begin
            x_n = x - (y >>> iter_cnt);
            y_n = y + (x >>> iter_cnt);
            z_n = z - atan_tab(iter_cnt);
        end
        real_n = negate ? -q20_to_q10(x_n) : q20_to_q10(x_n);
        imag_n = negate ? -q20_to_q10(y_n) : q20_to_q10(y_n);
    end

    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples the values from before the edge and the order of statements is
    // irrelevant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RESET_STATE;
            phase    <= '0;
            audio_q  <= '0;
            x        <= '0;
            y        <= '0;
            z        <= '0;
            negate   <= 1'b0;
            iter_cnt <= '0;
            real_out <= '0;
            imag_out <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!input_fifo_empty) begin
                        audio_q <= audio_in;
                        state   <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    phase    <= phase_next;
                    x        <= X_INIT;
                    y        <= '0;
                    z        <= z_init;
                    negate   <= fold;
                    iter_cnt <= '0;
                    state    <= S_ROTATE;
                end
                S_ROTATE: begin
                    x <= x_n;
                    y <= y_n;
                    z <= z_n;
                    // The outputs are loaded on the last step, so they are
                    // already valid in the first OUTPUT cycle.
                    if (iter_cnt == LAST_ITER) begin
                        real_out <= real_n;
                        imag_out <= imag_n;
                        state    <= S_OUTPUT;
                    end else begin
                        iter_cnt <= iter_cnt + 5'd1;
                    end
                end
                S_OUTPUT: begin
                    if (!out_fifos_full)
                        state <= S_IDLE;
                end
                S_LEADIN: begin
                    // The priming sample reuses OUTPUT for its write handshake.
                    real_out <= 32'h0000_0400;
                    imag_out <= '0;
                    state    <= S_OUTPUT;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
